// File: rtl/rk16_inst_decode_if.sv
// rk16_inst_decode_if: fetch-side instruction/stage inputs and decoded fields/strobes
interface rk16_inst_decode_if;
    logic [31:0] inst;
    logic [3:0]  stage;
    logic [15:0] imm;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  alu_func;
    logic        use_imm;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        branch;
    logic        jump;
    logic        illegal;
    modport master (
        output inst, stage,
        input  imm, opcode, rd, rs1, rs2, alu_func, use_imm,
               reg_we, mem_re, mem_we, branch, jump, illegal
    );
    modport slave (
        input  inst, stage,
        output imm, opcode, rd, rs1, rs2, alu_func, use_imm,
               reg_we, mem_re, mem_we, branch, jump, illegal
    );
endinterface

// File: rtl/rk16_inst_decode.sv
// rk16_inst_decode: RK16 field split and stage-qualified control strobes with held IR
module rk16_inst_decode (
    input logic             clk,
    input logic             rst_n,
    rk16_inst_decode_if.slave bus
);
    logic [31:0] ir;
    logic [31:0] src;
    logic [3:0]  op;
    logic        is_alu, is_alui, is_load, is_store, is_beqz, is_jal;
    // IR captures the fetched word in FETCH and holds it for the later stages; reset loads a NOP
    always_ff @(posedge clk) begin
        if (!rst_n)
            ir <= '0;
        else if (bus.stage == 4'd0)
            ir <= bus.inst;
    end
    // FETCH decodes the live word so fields are usable in the same cycle; later stages use IR
    always_comb begin
        src      = (bus.stage == 4'd0) ? bus.inst : ir;
        op       = src[3:0];
        is_alu   = op == 4'h1;
        is_alui  = op == 4'h2;
        is_load  = op == 4'h3;
        is_store = op == 4'h4;
        is_beqz  = op == 4'h5;
        is_jal   = op == 4'h6;
    end
    assign bus.imm      = src[31:16];
    assign bus.opcode   = op;
    assign bus.rd       = src[7:4];
    assign bus.rs1      = src[11:8];
    assign bus.rs2      = src[15:12];
    assign bus.illegal  = op > 4'h6;
    assign bus.alu_func = is_alu ? src[19:16] : is_alui ? src[15:12] : 4'h0;
    assign bus.use_imm  = is_alui | is_load | is_store | is_jal;
    assign bus.branch   = is_beqz & (bus.stage == 4'd2);
    assign bus.jump     = is_jal & (bus.stage == 4'd2);
    assign bus.mem_re   = is_load & (bus.stage == 4'd3);
    assign bus.mem_we   = is_store & (bus.stage == 4'd3);
    assign bus.reg_we   = (is_alu | is_alui | is_load | is_jal) & (bus.stage == 4'd4) & (src[7:4] != 4'h0);
endmodule

// File: tb/tb_rk16_inst_decode.sv
// tb_rk16_inst_decode: directed checks of decode fields, stage gating, IR capture and reset
module tb_rk16_inst_decode;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   total = 0;
    logic [4:0] stb;
    rk16_inst_decode_if bus ();
    rk16_inst_decode dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    assign stb = {bus.reg_we, bus.mem_re, bus.mem_we, bus.branch, bus.jump};
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic comb(input logic [31:0] w);
        @(negedge clk);
        bus.stage = 4'd0;
        bus.inst = w;
        #1;
    endtask
    task automatic capture(input logic [31:0] w);
        @(negedge clk);
        bus.stage = 4'd0;
        bus.inst = w;
        @(posedge clk);
        #1;
    endtask
    task automatic set_stage(input logic [3:0] s);
        bus.stage = s;
        #1;
    endtask
    initial begin
        rst_n = 1'b0;
        bus.stage = 4'd1;
        bus.inst = 32'hFFFF_FFF3;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_ir_opcode", {28'h0, bus.opcode}, 32'h0);
        chk("reset_ir_illegal", {31'h0, bus.illegal}, 32'h0);
        comb(32'h0000_0000);
        chk("nop_imm", {16'h0, bus.imm}, 32'h0);
        chk("nop_opcode", {28'h0, bus.opcode}, 32'h0);
        chk("nop_illegal", {31'h0, bus.illegal}, 32'h0);
        chk("nop_strobes", {27'h0, stb}, 32'h0);
        comb(32'h1234_1234);
        chk("st_fields", {bus.imm, bus.opcode, bus.rd, bus.rs1, bus.rs2}, 32'h1234_4321);
        chk("st_use_imm", {31'h0, bus.use_imm}, 32'h1);
        chk("st_alu_func", {28'h0, bus.alu_func}, 32'h0);
        chk("st_stage0_strobes", {27'h0, stb}, 32'h0);
        comb(32'h4567_4567);
        chk("ill7", {15'h0, bus.illegal, bus.imm}, 32'h1_4567);
        chk("ill7_strobes", {27'h0, stb}, 32'h0);
        comb(32'h89AB_89AB);
        chk("illB", {15'h0, bus.illegal, bus.imm}, 32'h1_89AB);
        comb(32'hCDEF_CDEF);
        chk("illF", {15'h0, bus.illegal, bus.imm}, 32'h1_CDEF);
        chk("illF_use_imm", {31'h0, bus.use_imm}, 32'h0);
        capture(32'h0010_0123);
        bus.inst = 32'hFFFF_FFFF;
        for (int s = 1; s <= 4; s++) begin
            set_stage(s[3:0]);
            chk($sformatf("ld_imm_s%0d", s), {16'h0, bus.imm}, 32'h0010);
            chk($sformatf("ld_illegal_s%0d", s), {31'h0, bus.illegal}, 32'h0);
            chk($sformatf("ld_strobes_s%0d", s), {27'h0, stb}, (s == 4) ? 32'h10 : (s == 3) ? 32'h08 : 32'h0);
        end
        capture(32'h0005_0102);
        set_stage(4'd4);
        chk("alui_rd0_reg_we", {31'h0, bus.reg_we}, 32'h0);
        chk("alui_alu_func", {27'h0, bus.use_imm, bus.alu_func}, 32'h10);
        capture(32'h0007_3211);
        set_stage(4'd4);
        chk("alu_strobes_s4", {27'h0, stb}, 32'h10);
        chk("alu_alu_func", {27'h0, bus.use_imm, bus.alu_func}, 32'h07);
        capture(32'h0003_0015);
        set_stage(4'd2);
        chk("beqz_strobes_s2", {27'h0, stb}, 32'h02);
        set_stage(4'd3);
        chk("beqz_strobes_s3", {27'h0, stb}, 32'h0);
        capture(32'h0002_0046);
        set_stage(4'd2);
        chk("jal_strobes_s2", {27'h0, stb}, 32'h01);
        set_stage(4'd4);
        chk("jal_strobes_s4", {27'h0, stb}, 32'h10);
        set_stage(4'd5);
        chk("jal_strobes_s5", {27'h0, stb}, 32'h0);
        capture(32'h0000_0047);
        set_stage(4'd4);
        chk("ill_strobes_s4", {26'h0, bus.illegal, stb}, 32'h20);
        capture(32'h0000_0004);
        set_stage(4'd3);
        chk("st_mem_we_s3", {27'h0, stb}, 32'h04);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_mid_opcode", {28'h0, bus.opcode}, 32'h0);
        chk("rst_mid_mem_we", {31'h0, bus.mem_we}, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, total);
        $finish;
    end
endmodule
